// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the three-floor car controller:
//   - default floor codes and the floor-code type
//   - FSM state enumeration
//   - floor-index helpers that answer "is any lamp lit above / below here?"
// Floors are handled internally as indices 0 (first), 1 (second), 2 (third);
// lamp vectors use the same indexing (bit 0 = first floor).
// -----------------------------------------------------------------------------
package elevator_pkg;

  typedef logic [1:0] floor_code_t;
  typedef logic [1:0] floor_idx_t;

  localparam floor_code_t ST_FLOOR_CODE = 2'b00;
  localparam floor_code_t ND_FLOOR_CODE = 2'b01;
  localparam floor_code_t RD_FLOOR_CODE = 2'b10;
  localparam int          NUM_FLOORS    = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } car_state_t;

  // Any lamp lit on a floor strictly above idx.
  function automatic logic req_above(input logic [NUM_FLOORS-1:0] leds,
                                     input floor_idx_t idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(idx)) r = r | leds[i];
    end
    return r;
  endfunction

  // Any lamp lit on a floor strictly below idx.
  function automatic logic req_below(input logic [NUM_FLOORS-1:0] leds,
                                     input floor_idx_t idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(idx)) r = r | leds[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/car_controller_if.sv
// -----------------------------------------------------------------------------
// car_controller_if
// Call buttons in, car status out.
//   st/nd/rd_button : level call request per floor (panel -> car)
//   state           : current floor code            (car -> panel)
//   st/nd/rd_led    : pending-request lamps         (car -> panel)
//   open_door       : door open                     (car -> panel)
//   moving          : car between floors            (car -> panel)
//   dir_up          : current / last travel direction, 1 = up
// master = button panel / environment, slave = car controller.
// -----------------------------------------------------------------------------
interface car_controller_if;
  import elevator_pkg::*;

  logic        st_button;
  logic        nd_button;
  logic        rd_button;
  floor_code_t state;
  logic        st_led;
  logic        nd_led;
  logic        rd_led;
  logic        open_door;
  logic        moving;
  logic        dir_up;

  modport master (
    output st_button, nd_button, rd_button,
    input  state, st_led, nd_led, rd_led, open_door, moving, dir_up
  );

  modport slave (
    input  st_button, nd_button, rd_button,
    output state, st_led, nd_led, rd_led, open_door, moving, dir_up
  );
endinterface

// File: rtl/car_controller_call_latch.sv
// -----------------------------------------------------------------------------
// call_latch
// One registered lamp per floor. A set request lights the lamp on the next
// edge unless it is blocked; a clear always wins over a set in the same cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (all lamps off)
//   i_set      : raw button levels
//   i_block    : suppress setting (door already open at that floor)
//   i_clear    : floor being served this edge
//   o_led      : lamp state (registered)
// -----------------------------------------------------------------------------
module call_latch
  import elevator_pkg::*;
#(
  parameter int N = NUM_FLOORS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_set,
  input  logic [N-1:0] i_block,
  input  logic [N-1:0] i_clear,
  output logic [N-1:0] o_led
);

  logic [N-1:0] r_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i_clear[i]) begin
          r_led[i] <= 1'b0;
        end else if (i_set[i] && !i_block[i]) begin
          r_led[i] <= 1'b1;
        end
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/car_controller.sv
// -----------------------------------------------------------------------------
// car_controller
// Three-floor elevator car: latches calls, chooses direction, times travel
// between floors and the door-open interval.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (car to first floor, idle, no calls)
//   car  : car_controller_if.slave (buttons in; floor, lamps, door, moving,
//          direction out -- all outputs registered)
// Parameters: floor codes, TRAVEL_CYCLES per floor hop, DOOR_CYCLES door open.
// -----------------------------------------------------------------------------
module car_controller
  import elevator_pkg::*;
#(
  parameter floor_code_t ST_FLOOR      = ST_FLOOR_CODE,
  parameter floor_code_t ND_FLOOR      = ND_FLOOR_CODE,
  parameter floor_code_t RD_FLOOR      = RD_FLOOR_CODE,
  parameter int          TRAVEL_CYCLES = 8,
  parameter int          DOOR_CYCLES   = 4
) (
  input logic             clk,
  input logic             rst,
  car_controller_if.slave car
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  // Counters run from LOAD down to 0, so a phase lasts LOAD+1 cycles.
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
  localparam floor_idx_t       TOP_IDX     = floor_idx_t'(NUM_FLOORS - 1);

  function automatic floor_code_t idx_to_code(input floor_idx_t idx);
    case (idx)
      2'd0:    return ST_FLOOR;
      2'd1:    return ND_FLOOR;
      default: return RD_FLOOR;
    endcase
  endfunction

  car_state_t       r_fsm,    w_fsm_next;
  floor_idx_t       r_floor,  w_floor_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;
  logic             r_dir_up, w_dir_next;
  floor_code_t      r_state;
  logic             r_moving;
  logic             r_open_door;

  logic [NUM_FLOORS-1:0] w_btn;
  logic [NUM_FLOORS-1:0] w_led;
  logic [NUM_FLOORS-1:0] w_clear;
  logic [NUM_FLOORS-1:0] w_block;
  floor_idx_t            w_arrive;
  logic                  w_above;
  logic                  w_below;

  assign w_btn   = {car.rd_button, car.nd_button, car.st_button};
  assign w_above = req_above(w_led, r_floor);
  assign w_below = req_below(w_led, r_floor);

  call_latch #(.N(NUM_FLOORS)) u_call_latch (
    .clk     (clk),
    .rst     (rst),
    .i_set   (w_btn),
    .i_block (w_block),
    .i_clear (w_clear),
    .o_led   (w_led)
  );

  always_comb begin
    w_fsm_next   = r_fsm;
    w_floor_next = r_floor;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir_up;
    w_clear      = '0;
    w_block      = '0;
    w_arrive     = r_floor;

    case (r_fsm)
      IDLE: begin
        w_cnt_next = '0;
        // A press at the current floor opens the door on the very next edge;
        // the same-edge clear keeps its lamp from ever lighting.
        if (w_led[r_floor] || w_btn[r_floor]) begin
          w_fsm_next        = DOOR_OPEN;
          w_clear[r_floor]  = 1'b1;
          w_cnt_next        = DOOR_LOAD;
        end else if (w_above && (r_dir_up || !w_below)) begin
          w_fsm_next = MOVE_UP;
          w_dir_next = 1'b1;
          w_cnt_next = TRAVEL_LOAD;
        end else if (w_below) begin
          w_fsm_next = MOVE_DOWN;
          w_dir_next = 1'b0;
          w_cnt_next = TRAVEL_LOAD;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          w_arrive     = (r_fsm == MOVE_UP) ? (r_floor + 2'd1) : (r_floor - 2'd1);
          w_floor_next = w_arrive;
          if (w_arrive == TOP_IDX) begin
            w_dir_next = 1'b0;
          end else if (w_arrive == 2'd0) begin
            w_dir_next = 1'b1;
          end

          if (w_led[w_arrive]) begin
            w_fsm_next        = DOOR_OPEN;
            w_clear[w_arrive] = 1'b1;
            w_cnt_next        = DOOR_LOAD;
          end else if ((r_fsm == MOVE_UP   && req_above(w_led, w_arrive)) ||
                       (r_fsm == MOVE_DOWN && req_below(w_led, w_arrive))) begin
            w_cnt_next = TRAVEL_LOAD;   // pass through, keep direction
          end else begin
            w_fsm_next = IDLE;
            w_cnt_next = '0;
          end
        end
      end

      DOOR_OPEN: begin
        // Calls for the floor being served hold the door instead of lighting.
        w_block[r_floor] = 1'b1;
        if (w_btn[r_floor]) begin
          w_cnt_next = DOOR_LOAD;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          w_fsm_next = IDLE;
        end
      end

      default: begin
        w_fsm_next = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_floor     <= 2'd0;
      r_cnt       <= '0;
      r_dir_up    <= 1'b1;
      r_state     <= ST_FLOOR;
      r_moving    <= 1'b0;
      r_open_door <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_floor     <= w_floor_next;
      r_cnt       <= w_cnt_next;
      r_dir_up    <= w_dir_next;
      r_state     <= idx_to_code(w_floor_next);
      r_moving    <= (w_fsm_next == MOVE_UP) || (w_fsm_next == MOVE_DOWN);
      r_open_door <= (w_fsm_next == DOOR_OPEN);
    end
  end

  assign car.state     = r_state;
  assign car.st_led    = w_led[0];
  assign car.nd_led    = w_led[1];
  assign car.rd_led    = w_led[2];
  assign car.open_door = r_open_door;
  assign car.moving    = r_moving;
  assign car.dir_up    = r_dir_up;

endmodule

// File: tb/tb_car_controller.sv
// -----------------------------------------------------------------------------
// tb_car_controller
// Directed scenarios push expected travel-hop / door-episode events into a
// queue; a monitor detects those episodes on the DUT outputs and compares.
// A random phase checks invariants and lamp service latency.
// -----------------------------------------------------------------------------
module tb_car_controller;
  import elevator_pkg::*;

  localparam int KIND_HOP  = 0;
  localparam int KIND_DOOR = 1;
  localparam int LAT_MAX   = 2 * (2 * 8 + 4 + 7);

  typedef struct {
    int kind;
    int floor;
    int cycles;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   scb_en = 1'b0;
  bit   rand_en = 1'b0;
  ev_t  exp_q[$];

  car_controller_if dut_if();

  car_controller #(
    .ST_FLOOR      (2'b00),
    .ND_FLOOR      (2'b01),
    .RD_FLOOR      (2'b10),
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .car (dut_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_max(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
    end
  endtask

  task automatic push(input int kind, input int floor, input int cycles);
    ev_t e;
    e.kind = kind; e.floor = floor; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  task automatic compare_event(input int kind, input int floor, input int cycles);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%0d floor=%0d cycles=%0d, required none",
               kind, floor, cycles);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d floor=%0d cycles=%0d (expected kind=%0d floor=%0d cycles=%0d)",
               kind, floor, cycles, e.kind, e.floor, e.cycles);
      check("ev_kind", kind, e.kind);
      check("ev_floor", floor, e.floor);
      check("ev_cycles", cycles, e.cycles);
    end
  endtask

  // Episode monitor: a floor hop completes when the floor code changes after
  // a moving sample; a door episode completes when open_door falls.
  initial begin : monitor
    logic [1:0] prev_state;
    logic       prev_mv;
    logic       prev_open;
    logic       hop;
    int         mv_cnt;
    int         dr_cnt;
    prev_state = 2'b00; prev_mv = 1'b0; prev_open = 1'b0;
    mv_cnt = 0; dr_cnt = 0;
    forever begin
      @(negedge clk);
      hop = (prev_mv === 1'b1) && (dut_if.state !== prev_state);
      if (scb_en && hop) compare_event(KIND_HOP, int'(dut_if.state), mv_cnt);
      if (hop || dut_if.moving !== 1'b1) mv_cnt = 0;
      if (dut_if.moving === 1'b1) mv_cnt++;
      if (scb_en && prev_open === 1'b1 && dut_if.open_door === 1'b0)
        compare_event(KIND_DOOR, int'(dut_if.state), dr_cnt);
      if (dut_if.open_door === 1'b1) dr_cnt++; else dr_cnt = 0;
      prev_state = dut_if.state;
      prev_mv    = dut_if.moving;
      prev_open  = dut_if.open_door;
    end
  end

  // Invariants and lamp latency during the random phase.
  initial begin : inv_monitor
    int age[3];
    logic [2:0] leds;
    for (int f = 0; f < 3; f++) age[f] = 0;
    forever begin
      @(negedge clk);
      if (rand_en) begin
        check("state_valid", int'(dut_if.state != 2'b11), 1);
        check("door_and_moving", int'(dut_if.open_door && dut_if.moving), 0);
        leds = {dut_if.rd_led, dut_if.nd_led, dut_if.st_led};
        for (int f = 0; f < 3; f++) begin
          if (leds[f]) begin
            age[f]++;
          end else begin
            if (age[f] != 0) check_max("led_latency", age[f], LAT_MAX);
            age[f] = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int leds_now();
    return int'({dut_if.rd_led, dut_if.nd_led, dut_if.st_led});
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(dut_if.moving === 1'b0 && dut_if.open_door === 1'b0 && leds_now() == 0)
           && n < 400) begin
      tick();
      n++;
    end
    check(name, int'(n < 400), 1);
    repeat (2) tick();
  endtask

  initial begin : stimulus
    logic [2:0] b;
    dut_if.st_button = 1'b0;
    dut_if.nd_button = 1'b0;
    dut_if.rd_button = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    $display("reset: state=%0d leds=%0d open=%0d moving=%0d dir_up=%0d",
             dut_if.state, leds_now(), dut_if.open_door, dut_if.moving, dut_if.dir_up);
    check("rst_state", int'(dut_if.state), 0);
    check("rst_leds", leds_now(), 0);
    check("rst_open", int'(dut_if.open_door), 0);
    check("rst_moving", int'(dut_if.moving), 0);
    check("rst_dir_up", int'(dut_if.dir_up), 1);
    scb_en = 1'b1;

    // Current-floor call while idle at first floor: door opens, lamp never lit.
    push(KIND_DOOR, 0, 4);
    dut_if.st_button = 1'b1; tick(); dut_if.st_button = 1'b0;
    $display("st call at floor 0: st_led=%0d open=%0d", dut_if.st_led, dut_if.open_door);
    check("t032_st_led", int'(dut_if.st_led), 0);
    check("t032_open", int'(dut_if.open_door), 1);
    begin
      int seen_mv;
      seen_mv = 0;
      repeat (5) begin
        if (dut_if.moving !== 1'b0) seen_mv = 1;
        tick();
      end
      check("t032_no_move", seen_mv, 0);
    end
    wait_idle("t032_idle");
    check("t032_q_empty", exp_q.size(), 0);

    // One-cycle call to second floor.
    push(KIND_HOP, 1, 8);
    push(KIND_DOOR, 1, 4);
    dut_if.nd_button = 1'b1; tick(); dut_if.nd_button = 1'b0;
    $display("nd call: nd_led=%0d moving=%0d", dut_if.nd_led, dut_if.moving);
    check("t031_nd_led", int'(dut_if.nd_led), 1);
    check("t031_not_yet_moving", int'(dut_if.moving), 0);
    tick();
    check("t031_moving", int'(dut_if.moving), 1);
    wait_idle("t031_idle");
    check("t031_state", int'(dut_if.state), 1);
    check("t031_nd_led_clear", int'(dut_if.nd_led), 0);
    check("t031_q_empty", exp_q.size(), 0);

    // Door hold: re-press current floor in door cycle 3 -> 3 + 4 cycles.
    push(KIND_DOOR, 1, 7);
    dut_if.nd_button = 1'b1; tick(); dut_if.nd_button = 1'b0;
    check("t034_open", int'(dut_if.open_door), 1);
    tick(); tick();
    dut_if.nd_button = 1'b1; tick(); dut_if.nd_button = 1'b0;
    $display("door hold: nd_led=%0d open=%0d", dut_if.nd_led, dut_if.open_door);
    check("t034_nd_led", int'(dut_if.nd_led), 0);
    check("t034_open_held", int'(dut_if.open_door), 1);
    wait_idle("t034_idle");
    check("t034_q_empty", exp_q.size(), 0);

    // Back down to first floor.
    push(KIND_HOP, 0, 8);
    push(KIND_DOOR, 0, 4);
    dut_if.st_button = 1'b1; tick(); dut_if.st_button = 1'b0;
    wait_idle("down_idle");
    check("down_state", int'(dut_if.state), 0);
    check("down_dir_up", int'(dut_if.dir_up), 1);
    check("down_q_empty", exp_q.size(), 0);

    // Third-floor call, second-floor call added during travel cycle 3.
    push(KIND_HOP, 1, 8);
    push(KIND_DOOR, 1, 4);
    push(KIND_HOP, 2, 8);
    push(KIND_DOOR, 2, 4);
    dut_if.rd_button = 1'b1; tick(); dut_if.rd_button = 1'b0;
    tick();
    check("t033_moving", int'(dut_if.moving), 1);
    tick(); tick();
    dut_if.nd_button = 1'b1; tick(); dut_if.nd_button = 1'b0;
    check("t033_nd_led", int'(dut_if.nd_led), 1);
    wait_idle("t033_idle");
    $display("two stops: state=%0d leds=%0d dir_up=%0d", dut_if.state, leds_now(), dut_if.dir_up);
    check("t033_state", int'(dut_if.state), 2);
    check("t033_leds", leds_now(), 0);
    check("t033_dir_up", int'(dut_if.dir_up), 0);
    check("t033_q_empty", exp_q.size(), 0);

    // Reset during travel cycle 5 with a pending third-floor call.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("t035_home", int'(dut_if.state), 0);
    dut_if.rd_button = 1'b1; tick(); dut_if.rd_button = 1'b0;
    tick();
    repeat (4) tick();
    check("t035_rd_led_pre", int'(dut_if.rd_led), 1);
    check("t035_moving_pre", int'(dut_if.moving), 1);
    rst = 1'b1;
    dut_if.nd_button = 1'b1;
    tick();
    rst = 1'b0;
    dut_if.nd_button = 1'b0;
    $display("reset mid-travel: state=%0d leds=%0d moving=%0d dir_up=%0d",
             dut_if.state, leds_now(), dut_if.moving, dut_if.dir_up);
    check("t035_state", int'(dut_if.state), 0);
    check("t035_leds", leds_now(), 0);
    check("t035_moving", int'(dut_if.moving), 0);
    check("t035_dir_up", int'(dut_if.dir_up), 1);
    check("t035_open", int'(dut_if.open_door), 0);
    repeat (3) tick();
    check("t035_discarded", int'(dut_if.moving), 0);
    check("t035_q_empty", exp_q.size(), 0);

    // Random calls; no re-presses of the floor the stopped car is at.
    scb_en  = 1'b0;
    rand_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int f = 0; f < 3; f++) b[f] = ($urandom_range(0, 7) == 0);
      if (dut_if.moving !== 1'b1 && dut_if.state != 2'b11) b[dut_if.state] = 1'b0;
      dut_if.st_button = b[0];
      dut_if.nd_button = b[1];
      dut_if.rd_button = b[2];
      tick();
    end
    dut_if.st_button = 1'b0;
    dut_if.nd_button = 1'b0;
    dut_if.rd_button = 1'b0;
    wait_idle("rand_drain");
    rand_en = 1'b0;
    check("rand_leds_final", leds_now(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_controller.md
CAR_CONTROLLER -- requirements
Module: car_controller

Interface
REQ-001 SHALL have parameter ST_FLOOR, default 2'b00, code of first floor.
REQ-002 SHALL have parameter ND_FLOOR, default 2'b01, code of second floor.
REQ-003 SHALL have parameter RD_FLOOR, default 2'b10, code of third floor.
REQ-004 SHALL have parameter TRAVEL_CYCLES, default 8, clock cycles to move one floor (>=2).
REQ-005 SHALL have parameter DOOR_CYCLES, default 4, clock cycles the door stays open (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports st_button, nd_button, rd_button  input  1 each  call request per floor, level, sampled every cycle.
REQ-009 SHALL have port state  output  2  current floor code; only ST_FLOOR, ND_FLOOR or RD_FLOOR.
REQ-010 SHALL have ports st_led, nd_led, rd_led  output  1 each  pending-request lamps.
REQ-011 SHALL have port open_door  output  1  door open.
REQ-012 SHALL have port moving  output  1  car between floors.
REQ-013 SHALL have port dir_up  output  1  current or last travel direction; 1 = up.

Function
REQ-014 A button high in cycle N SHALL set its LED in cycle N+1; an LED SHALL stay set until its floor is served.
REQ-015 The FSM SHALL have states IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN.
REQ-016 In IDLE, a set LED for the current floor SHALL go to DOOR_OPEN on the next edge, taking priority over all other requests.
REQ-017 In IDLE with no current-floor request, the FSM SHALL go to MOVE_UP if any LED above is set and dir_up=1, or if no LED below is set. Otherwise it SHALL go to MOVE_DOWN if any LED below is set.
REQ-018 In MOVE_UP/MOVE_DOWN, moving SHALL be 1. A travel counter SHALL count TRAVEL_CYCLES cycles, after which state SHALL step one floor in dir_up's direction.
REQ-019 On arrival, the FSM SHALL enter DOOR_OPEN if the arrival floor's LED is set. Otherwise it SHALL keep moving if an LED beyond lies in the same direction. Otherwise it SHALL return to IDLE.
REQ-020 On the entry edge to DOOR_OPEN, the current floor's LED SHALL clear. open_door SHALL be 1 for exactly DOOR_CYCLES consecutive cycles, then the FSM SHALL return to IDLE.
REQ-021 A button for the current floor during DOOR_OPEN SHALL NOT set its LED and SHALL reload the door counter to DOOR_CYCLES.
REQ-022 If a set and a clear of the same LED occur in one cycle, the clear SHALL win.
REQ-023 Buttons for other floors SHALL be latched in every state, including MOVE and DOOR_OPEN.
REQ-024 At RD_FLOOR, dir_up SHALL become 0; at ST_FLOOR, dir_up SHALL become 1. state SHALL never wrap or take 2'b11.
REQ-025 open_door and moving SHALL never both be 1. The door SHALL never open while moving.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 rst high at an edge SHALL force: state=ST_FLOOR, all LEDs=0, open_door=0, moving=0, dir_up=1, FSM=IDLE, counters=0.
REQ-028 Reset mid-travel or mid-door SHALL abandon the operation and discard all pending requests; buttons SHALL be ignored in the reset cycle.

Structure
REQ-029 Floor codes, FSM state enum, and above/below request helper functions SHALL live in shared package elevator_pkg.
REQ-030 The request latch (REQ-014, REQ-021, REQ-022) SHALL be sub-module call_latch. The FSM and counters SHALL be in car_controller.

Verification
REQ-031 After reset, pulse nd_button for 1 cycle. Required: nd_led=1 next cycle; moving=1 for 8 cycles; state=01; nd_led=0; open_door=1 for 4 cycles; then IDLE.
REQ-032 At floor 00 in IDLE, press st_button. Required: st_led stays 0 at the next edge; open_door=1 for 4 cycles; moving stays 0.
REQ-033 Press rd_button, then press nd_button 3 cycles into travel from 00. Required: stops at 01 with door 4 cycles, then continues to 10, door 4 cycles; all LEDs 0 at end.
REQ-034 At 01 with door open, press nd_button in door cycle 3. Required: nd_led stays 0; open_door lasts 3+4=7 cycles total.
REQ-035 Assert rst during cycle 5 of travel 00->01 with rd_led set. Required: next cycle state=00, LEDs=0, moving=0, dir_up=1.
REQ-036 Random buttons for 10k cycles. Required: state never 11; open_door&&moving never 1; every set LED clears within 2*(2*8+4+7) cycles.
